note_key_scheduler: RTL and testbench
=====================================

Name: note_key_scheduler

Overview:
- Shares a single programmable tone divider among NUM_KEYS piano keys.
- Synchronises and debounces the raw key vector, then picks one winning key by fixed priority, lowest index first. It applies an octave shift and drives a square wave on tone_out.
- Note changes and release take effect only on tone edges, so no glitches or runt pulses reach the speaker pin.
- Sits between the board key pins and the audio output pin, replacing per-note divider instances.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- NUM_KEYS, 12: number of key inputs. Key k maps to note k of the octave-5 table: C5 523, C#5 554, D5 587, D#5 622, E5 659, F5 698, F#5 740, G5 784, G#5 831, A5 880, A#5 932, B5 988 Hz.
- DEBOUNCE_CYC, 500000: cycles the synchronised key vector must stay stable before it is accepted (10 ms at 50 MHz).
- CNT_W, 25: width of the tone and debounce counters.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- keys, input, NUM_KEYS: raw key levels, asynchronous, 1 = pressed.
- octave, input, 2: 0 = octave 4, 1 = octave 5, 2 = octave 6, 3 = octave 7. Synchronised in the same way as keys.
- mute, input, 1: synchronous force-release request.
- tone_out, output, 1: square-wave audio output.
- note_active, output, 1: high while a note is sounding, including the release tail.
- note_idx, output, 4: index of the key currently sounding.

Behaviour:
- Reset (reset=0): all registers clear. tone_out=0, note_active=0, note_idx=0, accepted vector=0, state=IDLE.
- Synchronisation:
  - keys and octave each pass through 2 flops.
  - The debounce counter clears whenever the synchronised {octave,keys} differs from the previous cycle's value.
  - When the counter reaches DEBOUNCE_CYC-1 with no change, the accepted {octave,keys} register loads the synchronised value.
  - Total latency from pin change to accepted update is DEBOUNCE_CYC+2 cycles.
- Base divisor: base[k] = CLK_HZ/(2*f_k), integer-truncated and computed at elaboration (D#5 = 40192, A5 = 28409).
- Octave scaling: octave 0 gives base<<1, 1 gives base, 2 gives base>>1, 3 gives base>>2.
  - A result below 2 clamps to 2.
  - base<<1 must fit in CNT_W bits.
- Winner:
  - Lowest set bit of the accepted keys.
  - Target divisor is registered one cycle after accepted changes.
- Tone counter:
  - Counts 0..div-1.
  - At count == div-1, tone_out toggles and the counter returns to 0. Each half-period is therefore exactly div cycles.
- State IDLE:
  - tone_out=0, counter held at 0.
  - When accepted keys become nonzero and mute=0: load div and note_idx from the winner, set note_active=1, go to PLAY.
  - The first toggle to 1 occurs div cycles after entering PLAY.
- State PLAY:
  - If the winner or octave changes, latch the new div/idx as pending.
  - At the next toggle event, tone_out still toggles; then div and note_idx take the pending values and the counter restarts at 0.
  - Multiple changes before a toggle keep only the last one.
  - If accepted keys become zero or mute=1, go to RELEASE.
- State RELEASE:
  - Keep toggling with the current div until a toggle drives tone_out to 0.
  - On that edge, go to IDLE, set note_active=0 and clear the counter. note_idx holds its last value.
  - If tone_out is already 0 and the counter is mid-count, finish the low phase: the next toggle goes to 1, then wait for the following toggle to 0. A high phase is never truncated.
  - A new key press during RELEASE (mute=0) returns to PLAY with the new note pending, applied at the next toggle.
- mute held high keeps the block in IDLE regardless of keys.
- Simultaneous key change and toggle on the same cycle: the toggle uses the old div; the new div applies from the next counter restart.
- Reset asserted mid-note: immediate silence (tone_out=0) with no wait for an edge. Operation restarts in IDLE after reset deasserts, with the debounce counter restarted.

Test Plan (DEBOUNCE_CYC=4 unless noted):
1. Press key 3 (D#5), octave=1 → note_active rises 7 cycles after the pin change, note_idx=3; tone_out high and low phases each exactly 40192 cycles.
2. Hold keys 9 and 3 together → note_idx=3 (lowest index wins). Release key 3 → switch to idx 9 at the next toggle with no shortened phase; subsequent half-periods are 28409.
3. Hold A (key 9) and sweep octave 0/2/3 → half-periods 56818 / 14204 / 7102; each change lands on a toggle edge.
4. Release all keys mid-high phase → high phase completes, tone_out=0, note_active=0 at that edge; no further toggles.
5. Glitch key 5 for 3 cycles, then release → accepted vector never changes, note_active stays 0. A 5-cycle press is accepted.
6. Drive reset=0 mid-note → tone_out and note_active drop immediately. After release, assert mute=1 with a key held → block stays in IDLE.

Source files
------------

// File: rtl/note_key_scheduler_if.sv
// Key/octave/mute inputs and tone outputs of the shared-divider note scheduler.
// master drives the key side, slave is the scheduler itself.
interface note_key_scheduler_if #(
  parameter int NUM_KEYS = 12
);
  logic [NUM_KEYS-1:0] keys;
  logic [1:0]          octave;
  logic                mute;
  logic                tone_out;
  logic                note_active;
  logic [3:0]          note_idx;

  modport master (
    output keys,
    output octave,
    output mute,
    input  tone_out,
    input  note_active,
    input  note_idx
  );

  modport slave (
    input  keys,
    input  octave,
    input  mute,
    output tone_out,
    output note_active,
    output note_idx
  );
endinterface

// File: rtl/note_key_scheduler.sv
// One programmable square-wave divider shared by NUM_KEYS keys: lowest pressed key wins,
// octave shift applied, and note changes/release only ever land on tone edges.
module note_key_scheduler #(
  parameter int CLK_HZ       = 50000000,
  parameter int NUM_KEYS     = 12,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int CNT_W        = 25
) (
  input logic                 clk,
  input logic                 reset,
  note_key_scheduler_if.slave bus
);

  localparam int VEC_W = NUM_KEYS + 2;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RELEASE
  } state_t;

  function automatic int note_hz(input int k);
    case (k % 12)
      0:       return 523;
      1:       return 554;
      2:       return 587;
      3:       return 622;
      4:       return 659;
      5:       return 698;
      6:       return 740;
      7:       return 784;
      8:       return 831;
      9:       return 880;
      10:      return 932;
      default: return 988;
    endcase
  endfunction

  // Synchroniser, previous-cycle copy and debounced (accepted) vector, {octave, keys}
  logic [VEC_W-1:0] meta_reg;
  logic [VEC_W-1:0] sync_reg;
  logic [VEC_W-1:0] prev_reg;
  logic [VEC_W-1:0] accepted_reg;
  logic [CNT_W-1:0] deb_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg     <= '0;
      sync_reg     <= '0;
      prev_reg     <= '0;
      accepted_reg <= '0;
      deb_cnt_reg  <= '0;
    end else begin
      meta_reg <= {bus.octave, bus.keys};
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
      if (sync_reg != prev_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg != CNT_W'(DEBOUNCE_CYC - 1)) begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
        if (deb_cnt_reg == CNT_W'(DEBOUNCE_CYC - 2)) begin
          accepted_reg <= sync_reg;
        end
      end
    end
  end

  logic [NUM_KEYS-1:0] acc_keys;
  logic [1:0]          acc_oct;
  logic                key_any;

  assign acc_keys = accepted_reg[NUM_KEYS-1:0];
  assign acc_oct  = accepted_reg[VEC_W-1:NUM_KEYS];
  assign key_any  = |acc_keys;

  // Half-period table for octave 5, fixed at elaboration
  logic [CNT_W-1:0] base_div [NUM_KEYS];

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_base
    localparam int BASE = CLK_HZ / (2 * note_hz(gi));
    assign base_div[gi] = CNT_W'(BASE);
  end

  logic [3:0]       win_idx;
  logic [CNT_W-1:0] win_base;
  logic [CNT_W-1:0] win_scaled;
  logic [CNT_W-1:0] win_div;

  always_comb begin
    win_idx  = '0;
    win_base = base_div[0];
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (acc_keys[k]) begin
        win_idx  = 4'(k);
        win_base = base_div[k];
      end
    end
  end

  always_comb begin
    case (acc_oct)
      2'd0:    win_scaled = win_base << 1;
      2'd1:    win_scaled = win_base;
      2'd2:    win_scaled = win_base >> 1;
      default: win_scaled = win_base >> 2;
    endcase
    win_div = (win_scaled < CNT_W'(2)) ? CNT_W'(2) : win_scaled;
  end

  // Pending note for PLAY; held while no key is accepted so a release never loads garbage
  logic [CNT_W-1:0] tgt_div_reg;
  logic [3:0]       tgt_idx_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt_div_reg <= '0;
      tgt_idx_reg <= '0;
    end else if (key_any) begin
      tgt_div_reg <= win_div;
      tgt_idx_reg <= win_idx;
    end
  end

  state_t           state_reg;
  logic [CNT_W-1:0] tone_cnt_reg;
  logic [CNT_W-1:0] div_reg;
  logic [3:0]       idx_reg;
  logic             tone_reg;
  logic             active_reg;
  logic             toggle;
  logic             start_ok;

  assign toggle   = (tone_cnt_reg == div_reg - 1'b1);
  assign start_ok = key_any && !bus.mute;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      tone_cnt_reg <= '0;
      div_reg      <= '0;
      idx_reg      <= '0;
      tone_reg     <= 1'b0;
      active_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          tone_reg     <= 1'b0;
          tone_cnt_reg <= '0;
          if (start_ok) begin
            div_reg    <= win_div;
            idx_reg    <= win_idx;
            active_reg <= 1'b1;
            state_reg  <= PLAY;
          end
        end

        PLAY: begin
          // New pitch is only adopted at a counter restart, so no phase is shortened
          if (toggle) begin
            tone_reg     <= ~tone_reg;
            tone_cnt_reg <= '0;
            div_reg      <= tgt_div_reg;
            idx_reg      <= tgt_idx_reg;
          end else begin
            tone_cnt_reg <= tone_cnt_reg + 1'b1;
          end
          if (!start_ok) begin
            state_reg <= RELEASE;
          end
        end

        RELEASE: begin
          if (toggle) begin
            tone_reg     <= ~tone_reg;
            tone_cnt_reg <= '0;
          end else begin
            tone_cnt_reg <= tone_cnt_reg + 1'b1;
          end
          if (start_ok) begin
            state_reg <= PLAY;
          end else if (toggle && tone_reg) begin
            state_reg  <= IDLE;
            active_reg <= 1'b0;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.tone_out    = tone_reg;
  assign bus.note_active = active_reg;
  assign bus.note_idx    = idx_reg;

endmodule

// File: tb/tb_note_key_scheduler.sv
// Randomised bench for note_key_scheduler against a phase-countdown reference model,
// plus a full-rate (50 MHz) instance checking one absolute half-period.
module tb_note_key_scheduler;

  localparam int CLK_HZ = 12000;
  localparam int NK     = 12;
  localparam int DEB    = 4;
  localparam int CW     = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset2 = 1'b0;
  always #5 clk = ~clk;

  note_key_scheduler_if #(.NUM_KEYS(NK)) bus ();
  note_key_scheduler_if #(.NUM_KEYS(NK)) bus2 ();

  note_key_scheduler #(
    .CLK_HZ(CLK_HZ), .NUM_KEYS(NK), .DEBOUNCE_CYC(DEB), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  note_key_scheduler #(
    .CLK_HZ(50000000), .NUM_KEYS(NK), .DEBOUNCE_CYC(DEB), .CNT_W(25)
  ) dut_full (
    .clk(clk), .reset(reset2), .bus(bus2)
  );

  int checks = 0;
  int failures = 0;
  int txn = 0;
  logic aux_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_PLAY, M_REL} mstate_t;

  logic [NK+1:0] hist [0:DEB+1];
  logic [NK+1:0] m_acc;
  int            m_tgt_div, m_tgt_idx;
  mstate_t       m_state;
  logic          m_tone, m_active;
  int            m_idx, m_div, m_left;

  function automatic int note_freq(input int k);
    case (k)
      0: return 523;   1: return 554;  2: return 587;  3: return 622;
      4: return 659;   5: return 698;  6: return 740;  7: return 784;
      8: return 831;   9: return 880; 10: return 932;  default: return 988;
    endcase
  endfunction

  function automatic int model_div(input int k, input int oct);
    int base, d;
    base = CLK_HZ / (2 * note_freq(k));
    case (oct)
      0:       d = base * 2;
      1:       d = base;
      2:       d = base / 2;
      default: d = base / 4;
    endcase
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int lowest(input logic [NK-1:0] v);
    for (int k = 0; k < NK; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= DEB + 1; i++) hist[i] = '0;
    m_acc = '0; m_tgt_div = 0; m_tgt_idx = 0;
    m_state = M_IDLE; m_tone = 1'b0; m_active = 1'b0;
    m_idx = 0; m_div = 0; m_left = 0;
  endtask

  // One clock edge; v and mu are the pin values the DUT samples on that edge.
  task automatic model_step(input logic [NK+1:0] v, input logic mu);
    logic [NK+1:0] acc_prev;
    int tdiv_prev, tidx_prev, w;
    logic go, edge_now, stable;
    acc_prev  = m_acc;
    tdiv_prev = m_tgt_div;
    tidx_prev = m_tgt_idx;
    go = (acc_prev[NK-1:0] != '0) && !mu;

    // Accepted = the value seen two samples ago once it has held for DEB samples
    for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
    stable = 1'b1;
    for (int i = 3; i <= DEB + 1; i++) if (hist[i] !== hist[2]) stable = 1'b0;
    if (stable) m_acc = hist[2];

    if (acc_prev[NK-1:0] != '0) begin
      m_tgt_idx = lowest(acc_prev[NK-1:0]);
      m_tgt_div = model_div(m_tgt_idx, int'(acc_prev[NK+1:NK]));
    end

    case (m_state)
      M_IDLE: begin
        if (go) begin
          w = lowest(acc_prev[NK-1:0]);
          m_idx = w;
          m_div = model_div(w, int'(acc_prev[NK+1:NK]));
          m_left = m_div;
          m_active = 1'b1;
          m_state = M_PLAY;
        end
      end
      M_PLAY: begin
        m_left--;
        if (m_left == 0) begin
          m_tone = !m_tone;
          m_div = tdiv_prev;
          m_idx = tidx_prev;
          m_left = m_div;
        end
        if (!go) m_state = M_REL;
      end
      default: begin
        m_left--;
        edge_now = (m_left == 0);
        if (edge_now) begin
          m_tone = !m_tone;
          m_left = m_div;
        end
        if (go) m_state = M_PLAY;
        else if (edge_now && !m_tone) begin
          m_state = M_IDLE;
          m_active = 1'b0;
        end
      end
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic compare_outputs();
    check_eq("tone_out", 32'(bus.tone_out), 32'(m_tone));
    check_eq("note_active", 32'(bus.note_active), 32'(m_active));
    check_eq("note_idx", 32'(bus.note_idx), 32'(m_idx));
  endtask

  task automatic drive_cycles(input logic [NK+1:0] v, input logic mu, input int n);
    repeat (n) begin
      bus.keys   = v[NK-1:0];
      bus.octave = v[NK+1:NK];
      bus.mute   = mu;
      model_step(v, mu);
      @(negedge clk);
      compare_outputs();
    end
  endtask

  task automatic segment(input logic [NK-1:0] k, input logic [1:0] oct, input logic mu, input int n);
    txn++;
    $display("txn %0d keys=%03h octave=%0d mute=%0d cycles=%0d", txn, k, oct, mu, n);
    drive_cycles({oct, k}, mu, n);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    bus.keys = '0; bus.octave = 2'd0; bus.mute = 1'b0;
    #1;
    check_eq("rst_tone_now", 32'(bus.tone_out), 32'd0);
    check_eq("rst_active_now", 32'(bus.note_active), 32'd0);
    check_eq("rst_idx_now", 32'(bus.note_idx), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    segment('0, 2'd0, 1'b0, 10);
  endtask

  function automatic logic [NK-1:0] key_bit(input int k);
    logic [NK-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  // ---------------- main bench ----------------
  initial begin
    logic [NK-1:0] rk;
    int n;
    bus.keys = '0; bus.octave = 2'd0; bus.mute = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset_tone", 32'(bus.tone_out), 32'd0);
    check_eq("reset_active", 32'(bus.note_active), 32'd0);
    check_eq("reset_idx", 32'(bus.note_idx), 32'd0);
    reset = 1'b1;
    segment('0, 2'd1, 1'b0, 10);

    // Press key 3: note_active rises 7 cycles after the pin change
    txn++;
    $display("txn %0d keys=%03h octave=1 mute=0 cycles=7 latency", txn, key_bit(3));
    drive_cycles({2'd1, key_bit(3)}, 1'b0, 6);
    check_eq("latency_pre", 32'(bus.note_active), 32'd0);
    drive_cycles({2'd1, key_bit(3)}, 1'b0, 1);
    check_eq("latency_rise", 32'(bus.note_active), 32'd1);
    check_eq("first_idx", 32'(bus.note_idx), 32'd3);
    segment(key_bit(3), 2'd1, 1'b0, 60);

    segment(key_bit(3) | key_bit(9), 2'd1, 1'b0, 60);
    check_eq("prio_idx3", 32'(bus.note_idx), 32'd3);
    segment(key_bit(9), 2'd1, 1'b0, 60);
    check_eq("switch_idx9", 32'(bus.note_idx), 32'd9);
    segment(key_bit(9), 2'd0, 1'b0, 40);
    segment(key_bit(9), 2'd2, 1'b0, 40);
    segment(key_bit(9), 2'd3, 1'b0, 40);

    segment('0, 2'd3, 1'b0, 40);
    check_eq("released_active", 32'(bus.note_active), 32'd0);
    check_eq("released_tone", 32'(bus.tone_out), 32'd0);

    segment(key_bit(5), 2'd1, 1'b0, 3);
    segment('0, 2'd1, 1'b0, 20);
    check_eq("glitch_ignored", 32'(bus.note_active), 32'd0);
    segment(key_bit(5), 2'd1, 1'b0, 5);
    segment('0, 2'd1, 1'b0, 3);
    check_eq("press5_accepted", 32'(bus.note_active), 32'd1);
    segment('0, 2'd1, 1'b0, 40);

    segment(key_bit(3), 2'd1, 1'b0, 40);
    check_eq("pre_reset_active", 32'(bus.note_active), 32'd1);
    do_reset();
    segment(key_bit(3), 2'd1, 1'b1, 40);
    check_eq("mute_idle", 32'(bus.note_active), 32'd0);
    segment(key_bit(3), 2'd1, 1'b0, 20);
    check_eq("unmute_play", 32'(bus.note_active), 32'd1);

    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 3))
        0:       rk = '0;
        1, 2:    rk = key_bit($urandom_range(0, NK - 1));
        default: rk = NK'($urandom);
      endcase
      segment(rk, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
              $urandom_range(1, 40));
      if (i % 60 == 59) do_reset();
    end

    n = 0;
    while (!aux_done && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check_eq("full_rate_done", 32'(aux_done), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Full-rate instance: A5 at octave 7 must give 7102-cycle half-periods
  initial begin
    int n;
    bus2.keys = '0; bus2.octave = 2'd0; bus2.mute = 1'b0;
    repeat (3) @(negedge clk);
    reset2 = 1'b1;
    repeat (3) @(negedge clk);
    bus2.keys = key_bit(9);
    bus2.octave = 2'd3;
    n = 0;
    while (bus2.tone_out !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("full_rise_seen", 32'(bus2.tone_out), 32'd1);
    check_eq("full_idx9", 32'(bus2.note_idx), 32'd9);
    n = 0;
    while (bus2.tone_out === 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("full_high_phase", 32'(n), 32'd7102);
    n = 0;
    while (bus2.tone_out === 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("full_low_phase", 32'(n), 32'd7102);
    aux_done = 1'b1;
  end

endmodule
